fft_peak_detect: RTL and testbench

- Downstream consumer of the FFT core's output stream (real/imag, valid, last).
- Computes per-bin power re²+im² in a 3-stage pipeline and streams it out.
- Tracks the maximum-power bin over the positive-frequency half of each frame.
- Reports the peak index and power once per frame, one cycle after the frame's last power sample.

---
 rtl/fft_peak_detect_if.sv | 35 +++
 rtl/fft_peak_detect.sv | 158 +++++++++++++++
 tb/tb_fft_peak_detect.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_peak_detect_if.sv
// rtl/fft_peak_detect_if.sv - FFT output stream in, power stream and peak report out
interface fft_peak_detect_if #(
    parameter int IN_W  = 32,
    parameter int IDX_W = 10
);
    logic signed [IN_W-1:0]  data_in_re;
    logic signed [IN_W-1:0]  data_in_im;
    logic                    data_in_valid;
    logic                    data_in_last;
    logic                    data_in_ready;
    logic [2*IN_W:0]         pwr_out;
    logic [IDX_W-1:0]        pwr_idx;
    logic                    pwr_valid;
    logic                    pwr_last;
    logic [IDX_W-1:0]        peak_idx;
    logic [2*IN_W:0]         peak_pwr;
    logic                    peak_valid;
    logic                    frame_err;

    // Peak detector side
    modport slave (
        input  data_in_re, data_in_im, data_in_valid, data_in_last,
        output data_in_ready,
        output pwr_out, pwr_idx, pwr_valid, pwr_last,
        output peak_idx, peak_pwr, peak_valid, frame_err
    );

    // FFT core / consumer side
    modport master (
        output data_in_re, data_in_im, data_in_valid, data_in_last,
        input  data_in_ready,
        input  pwr_out, pwr_idx, pwr_valid, pwr_last,
        input  peak_idx, peak_pwr, peak_valid, frame_err
    );
endinterface

// File: rtl/fft_peak_detect.sv
// rtl/fft_peak_detect.sv - per-bin power pipeline and max-bin search; PEAK_SKIP_DC_EN excludes bin 0 from search
module fft_peak_detect #(
    parameter int NFFT  = 1024,
    parameter int IN_W  = 32,
    parameter int IDX_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    fft_peak_detect_if.slave bus
);
    localparam int PW = 2*IN_W + 1;
    localparam int MW = 2*IN_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFFT - 1);
    localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(NFFT / 2);
`ifdef PEAK_SKIP_DC_EN
    localparam bit SKIP_DC = 1'b1;
`else
    localparam bit SKIP_DC = 1'b0;
`endif

    logic             ready;
    logic             accept;
    logic [IDX_W-1:0] bin_cnt;

    logic signed [IN_W-1:0] s1_re, s1_im;
    logic [IDX_W-1:0]       s1_idx;
    logic                   s1_last, s1_valid;

    logic signed [MW-1:0]   s1_re_x, s1_im_x;
    logic signed [MW-1:0]   s2_pre, s2_pim;
    logic [IDX_W-1:0]       s2_idx;
    logic                   s2_last, s2_valid;

    logic [PW-1:0]          s3_pwr;
    logic [IDX_W-1:0]       s3_idx;
    logic                   s3_last, s3_valid;

    logic                   have_max;
    logic [PW-1:0]          max_pwr, nxt_pwr;
    logic [IDX_W-1:0]       max_idx, nxt_idx;
    logic                   in_range, take, frame_end;

    logic [IDX_W-1:0]       peak_idx_r;
    logic [PW-1:0]          peak_pwr_r;
    logic                   peak_valid_r, frame_err_r;

    assign accept = bus.data_in_valid && ready;

    // Ready rises on the first clock after reset release and never drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready <= 1'b0;
        else        ready <= 1'b1;
    end

    // Bin counter: tags accepted samples, restarts after last, wraps at NFFT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   bin_cnt <= '0;
        else if (accept) begin
            if (bus.data_in_last)     bin_cnt <= '0;
            else                      bin_cnt <= bin_cnt + 1'b1;
        end
    end

    // S1: capture the accepted sample with its tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_re <= '0; s1_im <= '0; s1_idx <= '0; s1_last <= 1'b0; s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_re   <= bus.data_in_re;
                s1_im   <= bus.data_in_im;
                s1_idx  <= bin_cnt;
                s1_last <= bus.data_in_last;
            end
        end
    end

    // Sign-extend before squaring so the full 2*IN_W product is kept
    assign s1_re_x = MW'(s1_re);
    assign s1_im_x = MW'(s1_im);

    // S2: squares of each component
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_pre <= '0; s2_pim <= '0; s2_idx <= '0; s2_last <= 1'b0; s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_pre   <= s1_re_x * s1_re_x;
            s2_pim   <= s1_im_x * s1_im_x;
            s2_idx   <= s1_idx;
            s2_last  <= s1_last;
        end
    end

    // S3: squares are non-negative, so zero-extend and add with a carry bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_pwr <= '0; s3_idx <= '0; s3_last <= 1'b0; s3_valid <= 1'b0;
        end else begin
            s3_valid <= s2_valid;
            s3_pwr   <= {1'b0, s2_pre} + {1'b0, s2_pim};
            s3_idx   <= s2_idx;
            s3_last  <= s2_last;
        end
    end

    // have_max is clear only at the start of a frame, so a missing last keeps
    // searching across the wrap as one merged frame
    assign in_range  = s3_valid && (s3_idx < HALF_IDX) && !(SKIP_DC && (s3_idx == '0));
    assign take      = in_range && (!have_max || (s3_pwr > max_pwr));
    assign frame_end = s3_valid && s3_last;

    // Running max including the sample currently at S3
    always_comb begin
        nxt_pwr = max_pwr;
        nxt_idx = max_idx;
        if (take) begin
            nxt_pwr = s3_pwr;
            nxt_idx = s3_idx;
        end
    end

    // Running max state: cleared at frame end, loaded by the first in-range sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_max <= 1'b0; max_pwr <= '0; max_idx <= '0;
        end else if (frame_end) begin
            have_max <= 1'b0; max_pwr <= '0; max_idx <= '0;
        end else if (take) begin
            have_max <= 1'b1; max_pwr <= s3_pwr; max_idx <= s3_idx;
        end
    end

    // Frame report and length check, one cycle after S3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_idx_r <= '0; peak_pwr_r <= '0; peak_valid_r <= 1'b0; frame_err_r <= 1'b0;
        end else begin
            peak_valid_r <= frame_end;
            frame_err_r  <= s3_valid && (s3_last != (s3_idx == LAST_IDX));
            if (frame_end) begin
                peak_idx_r <= nxt_idx;
                peak_pwr_r <= nxt_pwr;
            end
        end
    end

    assign bus.data_in_ready = ready;
    assign bus.pwr_out       = s3_pwr;
    assign bus.pwr_idx       = s3_idx;
    assign bus.pwr_valid     = s3_valid;
    assign bus.pwr_last      = s3_last;
    assign bus.peak_idx      = peak_idx_r;
    assign bus.peak_pwr      = peak_pwr_r;
    assign bus.peak_valid    = peak_valid_r;
    assign bus.frame_err     = frame_err_r;
endmodule

// File: tb/tb_fft_peak_detect.sv
// tb/tb_fft_peak_detect.sv - scoreboard bench for fft_peak_detect
module tb_fft_peak_detect;
    localparam int NFFT  = 1024;
    localparam int IN_W  = 32;
    localparam int IDX_W = 10;
    localparam int PW    = 2*IN_W + 1;
`ifdef PEAK_SKIP_DC_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_peak_detect_if #(.IN_W(IN_W), .IDX_W(IDX_W)) bus ();
    fft_peak_detect #(.NFFT(NFFT), .IN_W(IN_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [PW-1:0] pwr; logic [IDX_W-1:0] idx; logic last; int cyc; } pwr_exp_t;
    typedef struct { logic [PW-1:0] pwr; logic [IDX_W-1:0] idx; int cyc; } peak_exp_t;
    pwr_exp_t  pq[$];
    peak_exp_t kq[$];
    int        eq[$];
    int        n_peak_exp = 0, n_peak_seen = 0;

    // reference model state
    int                     m_idx = 0;
    logic                   m_have = 1'b0;
    logic [PW-1:0]          m_max = '0;
    logic [IDX_W-1:0]       m_maxi = '0;
    logic signed [IN_W-1:0] fre[int];
    logic signed [IN_W-1:0] fim[int];

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    pwr_exp_t  me;
    peak_exp_t mk;
    int        mev;

    // Output monitor: pops expectations as the DUT produces them
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pwr_valid) begin
                if (pq.size() == 0) chk("pwr_unexpected", 1, 0);
                else begin
                    me = pq.pop_front();
                    chk("pwr_out", bus.pwr_out, me.pwr);
                    chk("pwr_idx", PW'(bus.pwr_idx), PW'(me.idx));
                    chk("pwr_last", PW'(bus.pwr_last), PW'(me.last));
                    chk("pwr_cycle", PW'(cyc), PW'(me.cyc));
                end
            end else if (pq.size() > 0 && pq[0].cyc <= cyc) begin
                me = pq.pop_front();
                chk("pwr_missing", PW'(bus.pwr_valid), 1);
            end
            if (bus.peak_valid) begin
                n_peak_seen++;
                if (kq.size() == 0) chk("peak_unexpected", 1, 0);
                else begin
                    mk = kq.pop_front();
                    chk("peak_idx", PW'(bus.peak_idx), PW'(mk.idx));
                    chk("peak_pwr", bus.peak_pwr, mk.pwr);
                    chk("peak_cycle", PW'(cyc), PW'(mk.cyc));
                end
            end else if (kq.size() > 0 && kq[0].cyc <= cyc) begin
                mk = kq.pop_front();
                chk("peak_missing", PW'(bus.peak_valid), 1);
            end
            if (bus.frame_err) begin
                if (eq.size() == 0) chk("err_unexpected", 1, 0);
                else begin
                    mev = eq.pop_front();
                    chk("err_cycle", PW'(cyc), PW'(mev));
                end
            end else if (eq.size() > 0 && eq[0] <= cyc) begin
                mev = eq.pop_front();
                chk("err_missing", PW'(bus.frame_err), 1);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [IN_W-1:0] re, input logic signed [IN_W-1:0] im, input logic last);
        logic signed [PW-1:0] a, b;
        logic [PW-1:0]        p;
        logic [IDX_W-1:0]     idx;
        logic                 inr;
        pwr_exp_t             e;
        peak_exp_t            k;
        bus.data_in_re    = re;
        bus.data_in_im    = im;
        bus.data_in_valid = 1'b1;
        bus.data_in_last  = last;
        @(posedge clk);
        #1;
        bus.data_in_valid = 1'b0;
        bus.data_in_last  = 1'b0;
        a = re;
        b = im;
        p = a*a + b*b;
        idx = IDX_W'(m_idx);
        e = '{p, idx, last, cyc + 2};
        pq.push_back(e);
        inr = (m_idx < NFFT/2) && !(SKIP && m_idx == 0);
        if (inr && (!m_have || p > m_max)) begin
            m_max = p; m_maxi = idx; m_have = 1'b1;
        end
        if (last != (m_idx == NFFT-1)) eq.push_back(cyc + 3);
        if (last) begin
            k = '{m_max, m_maxi, cyc + 3};
            kq.push_back(k);
            n_peak_exp++;
            m_have = 1'b0; m_max = '0; m_maxi = '0; m_idx = 0;
        end else begin
            m_idx = (m_idx + 1) % NFFT;
        end
    endtask

    // n samples from the sparse bin table; last on the final one if lastf;
    // the first tog samples are each followed by one idle cycle
    task automatic frame(input int n, input logic lastf, input int tog);
        logic signed [IN_W-1:0] re, im;
        for (int i = 0; i < n; i++) begin
            re = fre.exists(m_idx) ? fre[m_idx] : '0;
            im = fim.exists(m_idx) ? fim[m_idx] : '0;
            send(re, im, lastf && (i == n-1));
            if (i < tog) idle(1);
        end
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 10 && !bus.data_in_ready; k++) idle(1);
        chk("ready_after_reset", PW'(bus.data_in_ready), 1);
    endtask

    initial begin
        bus.data_in_re = '0;
        bus.data_in_im = '0;
        bus.data_in_valid = 1'b0;
        bus.data_in_last = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", PW'(bus.data_in_ready), 0);
        chk("rst_pwr_valid", PW'(bus.pwr_valid), 0);
        chk("rst_peak_valid", PW'(bus.peak_valid), 0);
        chk("rst_frame_err", PW'(bus.frame_err), 0);
        chk("rst_peak_idx", PW'(bus.peak_idx), 0);
        chk("rst_peak_pwr", bus.peak_pwr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ready();

        // single peak at bin 37
        fre.delete(); fim.delete();
        fre[37] = 3; fim[37] = -4;
        frame(NFFT, 1'b1, 0);
        idle(5);
        chk("a_peak_idx", PW'(bus.peak_idx), 37);
        chk("a_peak_pwr", bus.peak_pwr, 25);

        // tie keeps the lower bin
        fre.delete(); fim.delete();
        fre[5] = 100; fre[9] = 100;
        frame(NFFT, 1'b1, 0);
        idle(5);
        chk("tie_peak_idx", PW'(bus.peak_idx), 5);
        chk("tie_peak_pwr", bus.peak_pwr, 10000);

        // upper-half bin ignored by search, still streamed
        fre.delete(); fim.delete();
        fre[1000] = 1000; fre[2] = 10;
        frame(NFFT, 1'b1, 0);
        idle(5);
        chk("mirror_peak_idx", PW'(bus.peak_idx), 2);
        chk("mirror_peak_pwr", bus.peak_pwr, 100);

        // extreme inputs with valid toggling at the start of the frame
        fre.delete(); fim.delete();
        fre[3] = 32'sh8000_0000; fim[3] = 32'sh8000_0000;
        fre[700] = 32'sh8000_0000; fim[700] = 32'sh8000_0000;
        frame(NFFT, 1'b1, 8);
        idle(5);
        chk("ext_peak_idx", PW'(bus.peak_idx), 3);
        chk("ext_peak_pwr", bus.peak_pwr, 65'h0_8000_0000_0000_0000);

        // short frame: last at idx 499
        fre.delete(); fim.delete();
        fre[100] = 7;
        frame(500, 1'b1, 0);
        idle(5);
        chk("short_peak_idx", PW'(bus.peak_idx), 100);
        chk("short_peak_pwr", bus.peak_pwr, 49);

        // missing last, then a closing frame: search spans both as one frame
        fre.delete(); fim.delete();
        fre[50] = 20;
        frame(NFFT, 1'b0, 0);
        fre.delete(); fim.delete();
        fre[60] = 10;
        frame(NFFT, 1'b1, 0);
        idle(5);
        chk("merged_peak_idx", PW'(bus.peak_idx), 50);
        chk("merged_peak_pwr", bus.peak_pwr, 400);

        // reset in the middle of a frame
        fre.delete(); fim.delete();
        fre[20] = 500;
        frame(300, 1'b0, 0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        pq.delete();
        m_idx = 0; m_have = 1'b0; m_max = '0; m_maxi = '0;
        @(negedge clk);
        chk("midrst_ready", PW'(bus.data_in_ready), 0);
        chk("midrst_pwr_valid", PW'(bus.pwr_valid), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ready();
        fre.delete(); fim.delete();
        fre[7] = 9;
        frame(NFFT, 1'b1, 0);
        idle(5);
        chk("postrst_peak_idx", PW'(bus.peak_idx), 7);
        chk("postrst_peak_pwr", bus.peak_pwr, 81);

        // DC bin largest
        fre.delete(); fim.delete();
        fre[0] = 1000; fre[200] = 30;
        frame(NFFT, 1'b1, 0);
        idle(5);
        chk("dc_peak_idx", PW'(bus.peak_idx), SKIP ? 200 : 0);
        chk("dc_peak_pwr", bus.peak_pwr, SKIP ? 900 : 1000000);

        idle(10);
        chk("pwr_queue_empty", PW'(pq.size()), 0);
        chk("peak_queue_empty", PW'(kq.size()), 0);
        chk("err_queue_empty", PW'(eq.size()), 0);
        chk("peak_count", PW'(n_peak_seen), PW'(n_peak_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
